vr_vc_converter: RTL and testbench
==================================

VR_VC_CONVERTER -- requirements
Module: vr_vc_converter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 Parameter CREDIT_NUM, default 2, credits granted by downstream after reset; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 s_data_i  input  DATA_WIDTH  upstream payload.
REQ-006 s_valid_i  input  1  upstream payload valid.
REQ-007 s_ready_o  output  1  block accepts payload this cycle.
REQ-008 m_data_o  output  DATA_WIDTH  downstream payload.
REQ-009 m_valid_o  output  1  single-cycle valid strobe; downstream has no backpressure.
REQ-010 m_credit_i  input  1  one-cycle pulse, one credit returned per asserted cycle.
REQ-011 credit_cnt_o  output  $clog2(CREDIT_NUM+1)  current credit count.
REQ-012 err_o  output  1  sticky credit-overflow flag.

Function
REQ-013 Internal credit counter cnt, width $clog2(CREDIT_NUM+1), range 0..CREDIT_NUM; credit_cnt_o = cnt.
REQ-014 s_ready_o = (cnt != 0); decoded from registered cnt only, no combinational path from m_credit_i or s_valid_i.
REQ-015 Accept = s_valid_i && s_ready_o at a posedge.
REQ-016 On accept: next cycle m_valid_o = 1 and m_data_o = captured s_data_i; latency exactly 1 cycle.
REQ-017 No accept: next cycle m_valid_o = 0; m_data_o holds its last value.
REQ-018 Back-to-back accepts produce back-to-back m_valid_o pulses, one per accept, in order, none dropped or duplicated.
REQ-019 cnt_next = cnt - accept + m_credit_i.
REQ-020 Accept and m_credit_i in the same cycle: cnt unchanged.
REQ-021 cnt == 0: s_ready_o = 0; a credit that cycle raises cnt to 1 and s_ready_o to 1 on the following cycle.
REQ-022 m_credit_i with cnt == CREDIT_NUM and no accept: cnt saturates at CREDIT_NUM; err_o set to 1 next cycle.
REQ-023 err_o stays 1 until reset; normal operation continues while it is set.
REQ-024 s_data_i is don't-care when s_valid_i = 0 and has no effect on any output.

Reset
REQ-025 rst_n low asynchronously forces m_valid_o = 0, m_data_o = 0, err_o = 0, cnt = CREDIT_NUM (hence s_ready_o = 1).
REQ-026 Reset asserted mid-operation discards any pending output strobe; credits in flight are not accounted for; cnt restarts at CREDIT_NUM.
REQ-027 First accept is permitted on the first posedge after rst_n deasserts.

Verification (DATA_WIDTH = 8, CREDIT_NUM = 2)
REQ-028 Reset: hold rst_n low -> m_valid_o = 0, m_data_o = 0x00, s_ready_o = 1, credit_cnt_o = 2, err_o = 0.
REQ-029 Credit exhaustion: drive 0xEE, 0xFF, 0x11 with s_valid_i held high and no credits -> m_valid_o pulses two consecutive cycles with 0xEE then 0xFF; credit_cnt_o = 0; s_ready_o = 0; 0x11 not accepted.
REQ-030 Credit return: from the REQ-029 state, pulse m_credit_i once with 0x11 still valid -> s_ready_o = 1 the next cycle; 0x11 accepted; m_valid_o pulses once with 0x11; credit_cnt_o = 0 again.
REQ-031 Simultaneous events: at credit_cnt_o = 1, accept 0x5A in the same cycle as an m_credit_i pulse -> credit_cnt_o stays 1; m_valid_o pulses with 0x5A.
REQ-032 Overflow: at credit_cnt_o = 2 and idle, pulse m_credit_i -> credit_cnt_o stays 2; err_o = 1 and remains 1 across further traffic until reset.
REQ-033 Mid-operation reset: assert rst_n low in the same cycle as an accept of 0x33 with credit_cnt_o = 1 -> no m_valid_o pulse; after release credit_cnt_o = 2, err_o = 0, s_ready_o = 1.

Source files
------------

// File: rtl/vr_vc_converter.sv
// vr_vc_converter
// Bridges a valid/ready upstream port onto a credit-based downstream port.
// One payload is forwarded per credit. Credits are replenished by single-cycle
// m_credit_i pulses from downstream.
//
// Parameters
//   DATA_WIDTH   payload width in bits
//   CREDIT_NUM   credits held after reset (1..255)
//
// Ports
//   clk           single clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   s_data_i      upstream payload
//   s_valid_i     upstream payload valid
//   s_ready_o     high while at least one credit is held
//   m_data_o      downstream payload, holds its value between strobes
//   m_valid_o     single-cycle strobe, one cycle after each accept
//   m_credit_i    one credit returned per asserted cycle
//   credit_cnt_o  current credit count
//   err_o         sticky flag, set when a credit arrives while the count is full
module vr_vc_converter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CREDIT_NUM = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH-1:0]              s_data_i,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    output logic [DATA_WIDTH-1:0]              m_data_o,
    output logic                               m_valid_o,
    input  logic                               m_credit_i,
    output logic [$clog2(CREDIT_NUM+1)-1:0]    credit_cnt_o,
    output logic                               err_o
);

    localparam int unsigned CntWidth = $clog2(CREDIT_NUM + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(CREDIT_NUM);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accept;

    // Ready depends only on the registered count, so there is no
    // combinational path from m_credit_i or s_valid_i.
    assign s_ready_o = (cnt_q != '0);
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept && !m_credit_i) begin
            cnt_d = cnt_q - CntOne;
        end else if (!accept && m_credit_i) begin
            // A credit beyond the initial grant is a downstream protocol
            // violation: saturate and flag it, keep running.
            if (cnt_q == CntMax) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= CntMax;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= accept;
            if (accept) begin
                data_q <= s_data_i;
            end
        end
    end

    assign m_valid_o    = valid_q;
    assign m_data_o     = data_q;
    assign credit_cnt_o = cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_vr_vc_converter.sv
// Self-checking bench for vr_vc_converter (DATA_WIDTH = 8, CREDIT_NUM = 2).
// The driver predicts each accepted payload and queues it with the cycle it
// must appear on; a monitor pops and compares whenever m_valid_o is seen.
module tb_vr_vc_converter;

    localparam int unsigned DW = 8;
    localparam int unsigned CN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_credit_i = 1'b0;
    logic [1:0]    credit_cnt_o;
    logic          err_o;

    vr_vc_converter #(
        .DATA_WIDTH (DW),
        .CREDIT_NUM (CN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_credit_i   (m_credit_i),
        .credit_cnt_o (credit_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] last_exp = '0;

    // Reference model state: credits held and the sticky error.
    int unsigned   m_cnt = CN;
    bit            m_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = CN;
        m_err = 1'b0;
        exp_q.delete();
        last_exp = '0;
    endtask

    // One cycle: at the negedge check visible state against the model, then
    // drive inputs for the coming posedge and advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
        exp_t e;
        bit   acc;
        @(negedge clk);
        chk("credit_cnt", 32'(credit_cnt_o), 32'(m_cnt));
        chk("s_ready", 32'(s_ready_o), 32'(m_cnt != 0));
        chk("err", 32'(err_o), 32'(m_err));
        s_valid_i  = v;
        s_data_i   = d;
        m_credit_i = c;
        acc = v && (m_cnt != 0);
        if (acc) begin
            e.data = d;
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        if (acc && !c) m_cnt = m_cnt - 1;
        else if (!acc && c) begin
            if (m_cnt == CN) m_err = 1'b1;
            else m_cnt = m_cnt + 1;
        end
    endtask

    // Monitor: compares every strobe against the queue head, flags strobes
    // that arrive late or never, and checks m_data_o holds between strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (m_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(m_data_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 32'(m_data_o), 32'(e.data));
                        chk("latency", cyc, e.due);
                        last_exp = e.data;
                    end
                end else begin
                    chk("m_data_hold", 32'(m_data_o), 32'(last_exp));
                    if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                        e = exp_q.pop_front();
                        chk("missing_valid", 32'(m_valid_o), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'h00);
        chk("rst_s_ready", 32'(s_ready_o), 32'd1);
        chk("rst_cnt", 32'(credit_cnt_o), 32'd2);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Credit exhaustion: 0xEE and 0xFF go out, 0x11 stalls.
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        chk("exhaust_cnt", 32'(credit_cnt_o), 32'd0);
        chk("exhaust_ready", 32'(s_ready_o), 32'd0);
        // Credit return lets 0x11 through, count back to 0.
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("return_cnt", 32'(credit_cnt_o), 32'd0);

        // Simultaneous accept and credit at count 1.
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("simul_cnt", 32'(credit_cnt_o), 32'd1);

        // Overflow: credit while full and idle.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hC3, 1'b0);
        chk("ovf_cnt", 32'(credit_cnt_o), 32'd2);
        chk("ovf_err", 32'(err_o), 32'd1);
        step(1'b1, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_sticky", 32'(err_o), 32'd1);

        // Mid-operation reset racing an accept of 0x33 at count 1.
        step(1'b1, 8'hA0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pre_rst_cnt", 32'(credit_cnt_o), 32'd1);
        s_valid_i = 1'b1;
        s_data_i  = 8'h33;
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        s_valid_i = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_no_valid", 32'(m_valid_o), 32'd0);
        chk("midrst_data", 32'(m_data_o), 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        chk("midrst_cnt", 32'(credit_cnt_o), 32'd2);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_ready", 32'(s_ready_o), 32'd1);
        // First posedge after release already accepts.
        step(1'b1, 8'h77, 1'b0);

        // Randomized traffic; data is random even when s_valid_i is low.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 70), 8'($urandom),
                 1'($urandom_range(0, 99) < 35));
        end

        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
